alu_sequencer: RTL and testbench
================================

ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 The block SHALL use `clk`, input, 1 bit, as its single clock; all state SHALL update on its rising edge.
REQ-002 The block SHALL use `rst`, input, 1 bit, as a synchronous, active-high reset.
REQ-003 The block SHALL have `in_valid`, input, 1 bit: an instruction is offered.
REQ-004 The block SHALL have `in_ready`, output, 1 bit: an instruction can be accepted.
REQ-005 The block SHALL have `instr`, input, 16 bits: [15:12] fs, [11:9] rd, [8:6] ra, [5:3] rb, [2:0] ignored.
REQ-006 The block SHALL have `wr_en`, input, 1 bit: host register write request.
REQ-007 The block SHALL have `wr_addr`, input, 3 bits, and `wr_data`, input, 16 bits: host write target and value.
REQ-008 The block SHALL have `alu_a` and `alu_b`, outputs, 16 bits each, registered: ALU operands.
REQ-009 The block SHALL have `alu_fs`, output, 4 bits, registered: ALU function select.
REQ-010 The block SHALL have `alu_result`, input, 16 bits: combinational ALU output for the current `alu_a`/`alu_b`/`alu_fs`.
REQ-011 The block SHALL have `result_out`, output, 16 bits: last written-back result.
REQ-012 The block SHALL have `z_flag`, output, 1 bit: last result was zero.
REQ-013 The block SHALL have `done` and `err`, outputs, 1 bit each: single-cycle completion and error pulses.
REQ-014 The block SHALL have `dbg_addr`, input, 3 bits, and `dbg_data`, output, 16 bits: combinational read of reg[dbg_addr].

Function
REQ-015 The block SHALL contain an 8x16 register file, r0..r7; r0 is an ordinary writable register.
REQ-016 The FSM SHALL have three states: IDLE, READ, EXEC.
REQ-017 `in_ready` SHALL be 1 only in IDLE with `wr_en`=0.
REQ-018 Handshake at edge T (`in_valid` && `in_ready`) SHALL latch `instr` and move to READ.
REQ-019 In READ, at edge T+1, the block SHALL load `alu_a`<=reg[ra], `alu_b`<=reg[rb], `alu_fs`<=fs, and move to EXEC.
REQ-020 In EXEC, at edge T+2, for a valid fs the block SHALL set reg[rd]<=`alu_result`, `result_out`<=`alu_result`, `z_flag`<=(`alu_result`==0), `done`<=1, and return to IDLE.
REQ-021 Latency SHALL be fixed: `done` is high for exactly the cycle after edge T+2, and `in_ready` is also high in that cycle; peak throughput is one instruction per 3 cycles.
REQ-022 `z_flag` SHALL be derived internally from `alu_result`; the ALU's own zero output SHALL NOT be used.
REQ-023 Valid fs codes SHALL be 0000-1000, 1011, 1100 and 1111.
REQ-024 Reserved fs codes 1001, 1010, 1101 and 1110 SHALL, in EXEC, cause no register write, leave `result_out`/`z_flag` unchanged, pulse `err` for one cycle instead of `done`, and return to IDLE.
REQ-025 In IDLE, `wr_en`=1 SHALL write `wr_data` to reg[`wr_addr`] at the edge; while `wr_en`=1 no instruction SHALL be accepted, even if `in_valid`=1.
REQ-026 `wr_en` in READ or EXEC SHALL be ignored (no write).
REQ-027 When rd==ra or rd==rb, operands SHALL be the pre-write values; the next instruction SHALL see the written value.
REQ-028 `alu_a`, `alu_b` and `alu_fs` SHALL hold their values outside READ.
REQ-029 `done` and `err` SHALL never be high in the same cycle.

Reset
REQ-030 `rst`=1 at an edge SHALL force: state=IDLE, all registers 0, `alu_a`=`alu_b`=0, `alu_fs`=0000, `result_out`=0, `z_flag`=0, `done`=`err`=0.
REQ-031 `rst` asserted in READ or EXEC SHALL abort the instruction with no write-back and no `done`/`err` pulse; `rst` SHALL take priority over `wr_en` and the handshake.
REQ-032 `in_ready` SHALL be 1 in the first cycle after `rst` deasserts, provided `wr_en`=0.

Verification
REQ-033 Host write r1=0x0005, r2=0x0003; then instr fs=0000, rd=3, ra=1, rb=2 -> `done` 3 cycles after accept; r3=0x0008; `result_out`=0x0008; `z_flag`=0.
REQ-034 fs=0001, rd=4, ra=1, rb=1 with r1=0x0005 -> r4=0x0000; `z_flag`=1; `alu_fs`=0001 during EXEC.
REQ-035 fs=1001 -> `err` pulse, no `done`; all registers, `result_out` and `z_flag` unchanged; `in_ready`=1 the following cycle.
REQ-036 `in_valid`=1 held continuously with 3 instructions queued -> accepts spaced exactly 3 cycles apart; `in_ready` low in READ/EXEC.
REQ-037 `wr_en`=1 and `in_valid`=1 together in IDLE -> write performed, instruction not accepted until `wr_en`=0.
REQ-038 `rst` pulse during EXEC of fs=0000, rd=5 -> r5=0, no `done`, state IDLE, `dbg_data`=0 for all addresses.

Source files
------------

// File: rtl/alu_sequencer.sv
// Three-state instruction sequencer around an external combinational ALU.
// Owns an 8x16 register file, fetches operands, and writes back results.
module alu_sequencer (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] instr,
    input  logic        wr_en,
    input  logic [2:0]  wr_addr,
    input  logic [15:0] wr_data,
    output logic [15:0] alu_a,
    output logic [15:0] alu_b,
    output logic [3:0]  alu_fs,
    input  logic [15:0] alu_result,
    output logic [15:0] result_out,
    output logic        z_flag,
    output logic        done,
    output logic        err,
    input  logic [2:0]  dbg_addr,
    output logic [15:0] dbg_data
);

    localparam int unsigned DW = 16;
    localparam int unsigned NR = 8;
    localparam int unsigned IW = 13;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        EXEC = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   instr_q, instr_d;
    logic [DW-1:0]   regs_q [NR];
    logic [DW-1:0]   regs_d [NR];
    logic [DW-1:0]   alu_a_q, alu_a_d;
    logic [DW-1:0]   alu_b_q, alu_b_d;
    logic [3:0]      alu_fs_q, alu_fs_d;
    logic [DW-1:0]   result_q, result_d;
    logic            z_q, z_d;
    logic            done_q, done_d;
    logic            err_q, err_d;

    logic [3:0]      fs_f;
    logic [2:0]      rd_f, ra_f, rb_f;
    logic            unused_instr_bits;

    assign unused_instr_bits = ^instr[2:0];

    assign fs_f = instr_q[12:9];
    assign rd_f = instr_q[8:6];
    assign ra_f = instr_q[5:3];
    assign rb_f = instr_q[2:0];

    // Reserved function codes are 1001, 1010, 1101 and 1110.
    function automatic logic fs_valid(input logic [3:0] fs);
        return (fs <= 4'd8) || (fs == 4'd11) || (fs == 4'd12) || (fs == 4'd15);
    endfunction

    always_comb begin
        state_d  = state_q;
        instr_d  = instr_q;
        regs_d   = regs_q;
        alu_a_d  = alu_a_q;
        alu_b_d  = alu_b_q;
        alu_fs_d = alu_fs_q;
        result_d = result_q;
        z_d      = z_q;
        done_d   = 1'b0;
        err_d    = 1'b0;

        case (state_q)
            IDLE: begin
                // Host write has priority and blocks instruction acceptance.
                if (wr_en) begin
                    regs_d[wr_addr] = wr_data;
                end else if (in_valid) begin
                    instr_d = instr[15:3];
                    state_d = READ;
                end
            end
            READ: begin
                alu_a_d  = regs_q[ra_f];
                alu_b_d  = regs_q[rb_f];
                alu_fs_d = fs_f;
                state_d  = EXEC;
            end
            EXEC: begin
                if (fs_valid(fs_f)) begin
                    regs_d[rd_f] = alu_result;
                    result_d     = alu_result;
                    z_d          = (alu_result == 16'd0);
                    done_d       = 1'b1;
                end else begin
                    err_d = 1'b1;
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            instr_q  <= '0;
            regs_q   <= '{default: '0};
            alu_a_q  <= '0;
            alu_b_q  <= '0;
            alu_fs_q <= '0;
            result_q <= '0;
            z_q      <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            instr_q  <= instr_d;
            regs_q   <= regs_d;
            alu_a_q  <= alu_a_d;
            alu_b_q  <= alu_b_d;
            alu_fs_q <= alu_fs_d;
            result_q <= result_d;
            z_q      <= z_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    assign in_ready   = (state_q == IDLE) && !wr_en;
    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;
    assign alu_fs     = alu_fs_q;
    assign result_out = result_q;
    assign z_flag     = z_q;
    assign done       = done_q;
    assign err        = err_q;
    assign dbg_data   = regs_q[dbg_addr];

endmodule

// File: tb/tb_alu_sequencer.sv
// Scoreboard bench for alu_sequencer: stimulus pushes expected completions,
// a negedge monitor pops and checks them whenever done/err pulses.
module tb_alu_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] instr;
    logic        wr_en;
    logic [2:0]  wr_addr;
    logic [15:0] wr_data;
    logic [15:0] alu_a, alu_b;
    logic [3:0]  alu_fs;
    logic [15:0] alu_result;
    logic [15:0] result_out;
    logic        z_flag, done, err;
    logic [2:0]  dbg_addr;
    logic [15:0] dbg_data;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    typedef struct {
        logic        is_err;
        logic [15:0] res;
        logic        z;
        int          cyc;
    } exp_t;

    exp_t sb[$];

    alu_sequencer dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .instr(instr), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .alu_a(alu_a), .alu_b(alu_b), .alu_fs(alu_fs), .alu_result(alu_result),
        .result_out(result_out), .z_flag(z_flag), .done(done), .err(err),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // External ALU model
    always_comb begin
        case (alu_fs)
            4'd0:    alu_result = alu_a + alu_b;
            4'd1:    alu_result = alu_a - alu_b;
            4'd2:    alu_result = alu_a & alu_b;
            4'd3:    alu_result = alu_a | alu_b;
            4'd4:    alu_result = alu_a ^ alu_b;
            4'd5:    alu_result = ~alu_a;
            4'd6:    alu_result = alu_a << 1;
            4'd7:    alu_result = alu_a >> 1;
            4'd8:    alu_result = alu_a;
            4'd11:   alu_result = alu_b;
            4'd12:   alu_result = alu_a + 16'd1;
            4'd15:   alu_result = 16'd0;
            default: alu_result = 16'hDEAD;
        endcase
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chk_reg(input logic [2:0] a, input logic [15:0] v);
        dbg_addr = a;
        #1;
        chk($sformatf("r%0d", a), 32'(dbg_data), 32'(v));
    endtask

    task automatic push_exp(input logic e, input logic [15:0] r, input logic z);
        sb.push_back('{is_err: e, res: r, z: z, cyc: cyc + 3});
    endtask

    // Monitor: every done/err pulse must match the oldest expected completion.
    always @(negedge clk) begin
        if (!rst && (done || err)) begin
            chk("done_err_exclusive", 32'(done & err), 32'd0);
            if (sb.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_pulse: done=%0b err=%0b with empty scoreboard", done, err);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("pulse_err", 32'(err), 32'(e.is_err));
                chk("pulse_done", 32'(done), 32'(!e.is_err));
                chk("result_out", 32'(result_out), 32'(e.res));
                chk("z_flag", 32'(z_flag), 32'(e.z));
                chk("pulse_latency", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic host_write(input logic [2:0] a, input logic [15:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    // Called just after a negedge; returns just after the negedge of the pulse cycle.
    task automatic do_instr(input logic [3:0] fs, input logic [2:0] rd, input logic [2:0] ra,
                            input logic [2:0] rb, input logic exp_err, input logic [15:0] exp_res,
                            input logic exp_z, input logic wr_during);
        int n;
        n = 0;
        instr = {fs, rd, ra, rb, 3'b000};
        in_valid = 1'b1;
        #1;
        while (!in_ready && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (!in_ready) begin
            n_tests++;
            n_fail++;
            $display("FAIL accept_timeout: instr 0x%0h never accepted", instr);
            in_valid = 1'b0;
            return;
        end
        push_exp(exp_err, exp_res, exp_z);
        @(negedge clk);
        in_valid = 1'b0;
        if (wr_during) begin
            wr_en = 1'b1; wr_addr = 3'd7; wr_data = 16'hFFFF;
        end
        @(negedge clk);
        #1;
        chk("alu_fs_exec", 32'(alu_fs), 32'(fs));
        chk("in_ready_exec", 32'(in_ready), 32'd0);
        @(negedge clk);
        wr_en = 1'b0;
        #1;
        chk("in_ready_after", 32'(in_ready), 32'd1);
    endtask

    logic [15:0] b2b_vec [3];
    logic [15:0] b2b_res [3];
    logic        b2b_z   [3];

    initial begin
        rst = 1'b1; in_valid = 1'b0; instr = '0; wr_en = 1'b0;
        wr_addr = '0; wr_data = '0; dbg_addr = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("reset_in_ready", 32'(in_ready), 32'd1);
        chk("reset_alu_a", 32'(alu_a), 32'd0);
        chk("reset_alu_b", 32'(alu_b), 32'd0);
        chk("reset_alu_fs", 32'(alu_fs), 32'd0);
        chk("reset_result", 32'(result_out), 32'd0);
        chk("reset_z", 32'(z_flag), 32'd0);
        chk("reset_pulses", 32'({done, err}), 32'd0);
        for (int i = 0; i < 8; i++) chk_reg(3'(i), 16'h0000);

        // Host write collides with an offered instruction
        wr_en = 1'b1; wr_addr = 3'd6; wr_data = 16'h1234;
        in_valid = 1'b1; instr = {4'd8, 3'd7, 3'd6, 3'd0, 3'b000};
        #1;
        chk("wr_blocks_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        wr_en = 1'b0;
        chk_reg(3'd6, 16'h1234);
        do_instr(4'd8, 3'd7, 3'd6, 3'd0, 1'b0, 16'h1234, 1'b0, 1'b0);
        chk_reg(3'd7, 16'h1234);

        host_write(3'd1, 16'h0005);
        host_write(3'd2, 16'h0003);

        do_instr(4'd0, 3'd3, 3'd1, 3'd2, 1'b0, 16'h0008, 1'b0, 1'b0);
        chk_reg(3'd3, 16'h0008);

        do_instr(4'd1, 3'd4, 3'd1, 3'd1, 1'b0, 16'h0000, 1'b1, 1'b0);
        chk_reg(3'd4, 16'h0000);

        // Reserved code: err only, state untouched
        do_instr(4'd9, 3'd1, 3'd1, 3'd2, 1'b1, 16'h0000, 1'b1, 1'b0);
        chk_reg(3'd1, 16'h0005);

        // rd==ra==rb with host write attempted in READ/EXEC
        do_instr(4'd0, 3'd1, 3'd1, 3'd1, 1'b0, 16'h000A, 1'b0, 1'b1);
        chk_reg(3'd1, 16'h000A);
        chk_reg(3'd7, 16'h1234);
        do_instr(4'd0, 3'd2, 3'd1, 3'd2, 1'b0, 16'h000D, 1'b0, 1'b0);
        chk_reg(3'd2, 16'h000D);

        // Back-to-back with in_valid held high
        b2b_vec[0] = {4'd4, 3'd5, 3'd1, 3'd2, 3'b000}; b2b_res[0] = 16'h0007; b2b_z[0] = 1'b0;
        b2b_vec[1] = {4'd3, 3'd0, 3'd1, 3'd2, 3'b000}; b2b_res[1] = 16'h000F; b2b_z[1] = 1'b0;
        b2b_vec[2] = {4'd15, 3'd6, 3'd1, 3'd2, 3'b000}; b2b_res[2] = 16'h0000; b2b_z[2] = 1'b1;
        begin
            int acc_cyc [3];
            int k;
            k = 0;
            @(negedge clk);
            instr = b2b_vec[0];
            in_valid = 1'b1;
            for (int n = 0; n < 30 && k < 3; n++) begin
                #1;
                if (in_ready) begin
                    push_exp(1'b0, b2b_res[k], b2b_z[k]);
                    acc_cyc[k] = cyc;
                    if (k > 0) chk("b2b_spacing", 32'(cyc - acc_cyc[k-1]), 32'd3);
                    k++;
                end
                @(negedge clk);
                if (k < 3) instr = b2b_vec[k];
                else in_valid = 1'b0;
            end
            if (k < 3) begin
                n_tests++;
                n_fail++;
                $display("FAIL b2b_timeout: only %0d of 3 accepted", k);
                in_valid = 1'b0;
            end
            repeat (3) @(negedge clk);
        end
        chk_reg(3'd5, 16'h0007);
        chk_reg(3'd0, 16'h000F);
        chk_reg(3'd6, 16'h0000);

        // Reset during EXEC aborts the instruction
        instr = {4'd0, 3'd5, 3'd1, 3'd2, 3'b000};
        in_valid = 1'b1;
        #1;
        chk("abort_accept_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("abort_no_done", 32'({done, err}), 32'd0);
        chk("abort_in_ready", 32'(in_ready), 32'd1);
        chk("abort_alu_a", 32'(alu_a), 32'd0);
        chk("abort_result", 32'(result_out), 32'd0);
        for (int i = 0; i < 8; i++) chk_reg(3'(i), 16'h0000);
        repeat (4) @(negedge clk);
        #1;
        chk("abort_still_quiet", 32'({done, err}), 32'd0);
        chk("sb_empty", 32'(sb.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
